// File: rtl/imem_loader_pkg.sv
// Shared types and frame-length helpers for the PAT instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        READY   = 2'd2,
        WRITE   = 2'd3
    } state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // A full frame carries address and data; a burst frame carries data only.
    function automatic int full_beats(input int addr_w, input int data_w, input int port_w);
        return ceil_div(addr_w + data_w, port_w);
    endfunction

    function automatic int data_beats(input int data_w, input int port_w);
        return ceil_div(data_w, port_w);
    endfunction

    localparam int DEF_FULL_BEATS = full_beats(10, 40, 8);
    localparam int DEF_DATA_BEATS = data_beats(40, 8);

endpackage

// File: rtl/imem_loader_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pad input with rising-edge detect.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_int,
    input  logic reset_n,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk_int or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles write frames from synchronised pad beats
// in MEMLOAD mode, with burst auto-increment, error flags and a beat checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int PORT_W      = 8,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 40,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_int,
    input  logic              reset_n,
    input  logic              load_en,
    input  logic [PORT_W-1:0] port_in,
    input  logic              strobe_in,
    input  logic              write_in,
    input  logic              auto_inc,
    output logic [ADDR_W-1:0] imem_write_adr,
    output logic [DATA_W-1:0] imem_in,
    output logic              imem_write,
    output logic              frame_ready,
    output logic              err_overrun,
    output logic              err_short,
    output logic [PORT_W-1:0] checksum
);

    localparam int FULL_BEATS = full_beats(ADDR_W, DATA_W, PORT_W);
    localparam int DATA_BEATS = data_beats(DATA_W, PORT_W);
    localparam int FRAME_W    = ADDR_W + DATA_W;
    localparam int CNT_W      = $clog2(FULL_BEATS + 1);

    logic [PORT_W-1:0]  r_port_sync [SYNC_STAGES];
    logic [PORT_W-1:0]  w_port_beat;
    logic               w_strobe_rise;
    logic               w_write_rise;

    state_t             r_state;
    state_t             w_state_next;

    // Only the bits that can reach the address and data fields are kept.
    logic [FRAME_W-1:0] r_shifter;
    logic [FRAME_W-1:0] w_shift_next;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]   w_cnt_base;
    logic [CNT_W-1:0]   w_frame_len;
    logic               r_data_only;
    logic               r_addr_valid;
    logic               w_addr_valid_eff;
    logic               w_data_only;
    logic               w_frame_done;

    logic               w_accept;
    logic               w_commit;
    logic               w_set_overrun;
    logic               w_set_short;

    logic [ADDR_W-1:0]  r_imem_adr;
    logic [DATA_W-1:0]  r_imem_data;
    logic               r_imem_write;
    logic               r_err_overrun;
    logic               r_err_short;
    logic [PORT_W-1:0]  r_checksum;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_sync (
        .clk_int (clk_int),
        .reset_n (reset_n),
        .i_async (strobe_in),
        .o_rise  (w_strobe_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_write_sync (
        .clk_int (clk_int),
        .reset_n (reset_n),
        .i_async (write_in),
        .o_rise  (w_write_rise)
    );

    always_ff @(posedge clk_int or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_port_sync[i] <= '0;
            end
        end else begin
            r_port_sync[0] <= port_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_port_sync[i] <= r_port_sync[i-1];
            end
        end
    end

    assign w_port_beat  = r_port_sync[SYNC_STAGES-1];
    assign w_shift_next = FRAME_W'({r_shifter, w_port_beat});

    // A beat accepted alongside a commit opens the next frame, which already sees the new address.
    assign w_cnt_base       = (r_state == READY) ? '0 : r_beat_cnt;
    assign w_addr_valid_eff = r_addr_valid | (r_state == READY);
    assign w_data_only      = (w_cnt_base == '0) ? (auto_inc & w_addr_valid_eff) : r_data_only;
    assign w_frame_len      = w_data_only ? CNT_W'(DATA_BEATS) : CNT_W'(FULL_BEATS);
    assign w_frame_done     = ((w_cnt_base + CNT_W'(1)) == w_frame_len);

    always_ff @(posedge clk_int or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_commit      = 1'b0;
        w_set_overrun = 1'b0;
        w_set_short   = 1'b0;
        if (!load_en) begin
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_next = COLLECT;
                end
                COLLECT: begin
                    if (w_write_rise) begin
                        w_set_short = 1'b1;
                    end
                    if (w_strobe_rise) begin
                        w_accept = 1'b1;
                        if (w_frame_done) begin
                            w_state_next = READY;
                        end
                    end
                end
                READY: begin
                    if (w_write_rise) begin
                        w_commit     = 1'b1;
                        w_accept     = w_strobe_rise;
                        w_state_next = WRITE;
                    end else if (w_strobe_rise) begin
                        w_set_overrun = 1'b1;
                    end
                end
                WRITE: begin
                    w_state_next = COLLECT;
                    if (w_strobe_rise) begin
                        w_accept = 1'b1;
                        if (w_frame_done) begin
                            w_state_next = READY;
                        end
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // Leaving MEMLOAD mode discards the session but keeps the last written address and data.
    always_ff @(posedge clk_int or negedge reset_n) begin
        if (!reset_n) begin
            r_shifter     <= '0;
            r_beat_cnt    <= '0;
            r_data_only   <= 1'b0;
            r_addr_valid  <= 1'b0;
            r_imem_adr    <= '0;
            r_imem_data   <= '0;
            r_imem_write  <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_short   <= 1'b0;
            r_checksum    <= '0;
        end else if (!load_en || r_state == IDLE) begin
            r_beat_cnt    <= '0;
            r_data_only   <= 1'b0;
            r_addr_valid  <= 1'b0;
            r_imem_write  <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_short   <= 1'b0;
            r_checksum    <= '0;
        end else begin
            r_imem_write <= (r_state == WRITE);
            if (w_set_overrun) begin
                r_err_overrun <= 1'b1;
            end
            if (w_set_short) begin
                r_err_short <= 1'b1;
            end
            if (w_commit) begin
                r_imem_data  <= r_shifter[DATA_W-1:0];
                r_imem_adr   <= r_data_only ? (r_imem_adr + 1'b1) : r_shifter[FRAME_W-1:DATA_W];
                r_addr_valid <= 1'b1;
                r_beat_cnt   <= '0;
            end
            if (w_accept) begin
                r_shifter   <= w_shift_next;
                r_checksum  <= r_checksum ^ w_port_beat;
                r_beat_cnt  <= w_cnt_base + CNT_W'(1);
                r_data_only <= w_data_only;
            end
        end
    end

    assign imem_write_adr = r_imem_adr;
    assign imem_in        = r_imem_data;
    assign imem_write     = r_imem_write;
    assign frame_ready    = (r_state == READY);
    assign err_overrun    = r_err_overrun;
    assign err_short      = r_err_short;
    assign checksum       = r_checksum;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus random beat/write
// traffic compared every cycle against a frame-level model.
module tb_imem_loader;

    localparam int PORT_W      = 8;
    localparam int ADDR_W      = 10;
    localparam int DATA_W      = 40;
    localparam int SYNC_STAGES = 2;
    localparam int FULL_BEATS  = 7;
    localparam int DATA_BEATS  = 5;
    localparam int HOLD        = SYNC_STAGES + 2;

    logic              clk_int   = 1'b0;
    logic              reset_n   = 1'b1;
    logic              load_en   = 1'b0;
    logic [PORT_W-1:0] port_in   = '0;
    logic              strobe_in = 1'b0;
    logic              write_in  = 1'b0;
    logic              auto_inc  = 1'b0;
    logic [ADDR_W-1:0] imem_write_adr;
    logic [DATA_W-1:0] imem_in;
    logic              imem_write;
    logic              frame_ready;
    logic              err_overrun;
    logic              err_short;
    logic [PORT_W-1:0] checksum;

    imem_loader #(
        .PORT_W      (PORT_W),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_int        (clk_int),
        .reset_n        (reset_n),
        .load_en        (load_en),
        .port_in        (port_in),
        .strobe_in      (strobe_in),
        .write_in       (write_in),
        .auto_inc       (auto_inc),
        .imem_write_adr (imem_write_adr),
        .imem_in        (imem_in),
        .imem_write     (imem_write),
        .frame_ready    (frame_ready),
        .err_overrun    (err_overrun),
        .err_short      (err_short),
        .checksum       (checksum)
    );

    always #5 clk_int = ~clk_int;

    int checksRun    = 0;
    int checksPassed = 0;
    int dutPulses    = 0;
    int expPulses    = 0;
    bit compareOn    = 1'b0;

    // Frame-level reference: beats queue up until a frame is complete, a commit
    // turns the queued beats into one number and slices address and data out of it.
    logic [ADDR_W-1:0] expAdr;
    logic [DATA_W-1:0] expData;
    logic              expWr, expReady, expOvr, expShort;
    logic [PORT_W-1:0] expCks;
    logic [PORT_W-1:0] beatQ[$];
    bit                mStarted, mAddrValid, mDataOnly, mWritePending;
    logic              histStr [SYNC_STAGES+1];
    logic              histWr  [SYNC_STAGES+1];
    logic [PORT_W-1:0] histPort[SYNC_STAGES+1];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checksRun++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic clearSession();
        beatQ.delete();
        expCks        = '0;
        expOvr        = 1'b0;
        expShort      = 1'b0;
        expReady      = 1'b0;
        mAddrValid    = 1'b0;
        mDataOnly     = 1'b0;
        mWritePending = 1'b0;
    endtask

    task automatic modelReset();
        clearSession();
        expAdr   = '0;
        expData  = '0;
        expWr    = 1'b0;
        mStarted = 1'b0;
        for (int j = 0; j <= SYNC_STAGES; j++) begin
            histStr[j]  = 1'b0;
            histWr[j]   = 1'b0;
            histPort[j] = '0;
        end
    endtask

    task automatic takeBeat(input logic [PORT_W-1:0] b);
        if (beatQ.size() == 0) begin
            mDataOnly = auto_inc && mAddrValid;
        end
        beatQ.push_back(b);
        expCks = expCks ^ b;
        if (beatQ.size() == (mDataOnly ? DATA_BEATS : FULL_BEATS)) begin
            expReady = 1'b1;
        end
    endtask

    task automatic commitFrame();
        logic [63:0] acc;
        acc = '0;
        foreach (beatQ[i]) begin
            acc = (acc << PORT_W) | 64'(beatQ[i]);
        end
        expData = acc[DATA_W-1:0];
        if (mDataOnly) begin
            expAdr = ADDR_W'(expAdr + 1);
        end else begin
            expAdr = acc[ADDR_W+DATA_W-1:DATA_W];
        end
        mAddrValid = 1'b1;
        beatQ.delete();
    endtask

    task automatic modelStep();
        logic strRise, wrRise, inWrite;
        logic [PORT_W-1:0] beat;
        strRise = histStr[SYNC_STAGES-1] && !histStr[SYNC_STAGES];
        wrRise  = histWr[SYNC_STAGES-1] && !histWr[SYNC_STAGES];
        beat    = histPort[SYNC_STAGES-1];
        inWrite = mWritePending;
        expWr   = inWrite && load_en;
        if (expWr) expPulses++;
        mWritePending = 1'b0;
        if (!load_en || !mStarted) begin
            clearSession();
            mStarted = load_en;
        end else if (expReady) begin
            if (wrRise) begin
                commitFrame();
                expReady      = 1'b0;
                mWritePending = 1'b1;
                if (strRise) takeBeat(beat);
            end else if (strRise) begin
                expOvr = 1'b1;
            end
        end else begin
            if (wrRise && !inWrite) expShort = 1'b1;
            if (strRise) takeBeat(beat);
        end
        for (int j = SYNC_STAGES; j > 0; j--) begin
            histStr[j]  = histStr[j-1];
            histWr[j]   = histWr[j-1];
            histPort[j] = histPort[j-1];
        end
        histStr[0]  = strobe_in;
        histWr[0]   = write_in;
        histPort[0] = port_in;
    endtask

    always @(posedge clk_int or negedge reset_n) begin
        if (!reset_n) modelReset();
        else          modelStep();
    end

    always @(negedge clk_int) begin
        if (compareOn) begin
            checkOutput("cycle{adr,data,wr,rdy,ovr,short,cks}",
                {2'b00, imem_write_adr, imem_in, imem_write, frame_ready, err_overrun, err_short, checksum},
                {2'b00, expAdr, expData, expWr, expReady, expOvr, expShort, expCks});
            if (imem_write === 1'b1) dutPulses++;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_int);
    endtask

    task automatic sendBeat(input logic [PORT_W-1:0] b);
        port_in = b;
        waitCycles(1);
        strobe_in = 1'b1;
        waitCycles(HOLD);
        strobe_in = 1'b0;
        waitCycles(HOLD);
    endtask

    task automatic sendWrite();
        write_in = 1'b1;
        waitCycles(HOLD);
        write_in = 1'b0;
        waitCycles(HOLD);
    endtask

    task automatic sendBoth(input logic [PORT_W-1:0] b);
        port_in = b;
        waitCycles(1);
        strobe_in = 1'b1;
        write_in  = 1'b1;
        waitCycles(HOLD);
        strobe_in = 1'b0;
        write_in  = 1'b0;
        waitCycles(HOLD);
    endtask

    task automatic sendBytes(input logic [63:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sendBeat(val[i*PORT_W +: PORT_W]);
        end
    endtask

    task automatic restartSession();
        load_en = 1'b0;
        waitCycles(3);
        load_en = 1'b1;
        waitCycles(2);
    endtask

    task automatic applyStimulus(input int ops);
        int pick;
        logic [PORT_W-1:0] b;
        for (int i = 0; i < ops; i++) begin
            pick = $urandom_range(0, 99);
            b    = PORT_W'($urandom);
            if (pick < 65)      sendBeat(b);
            else if (pick < 80) sendWrite();
            else if (pick < 87) sendBoth(b);
            else if (pick < 94) begin auto_inc = ~auto_inc; waitCycles(1); end
            else                restartSession();
        end
    endtask

    int mark;

    initial begin
        #1 reset_n = 1'b0;
        #1;
        compareOn = 1'b1;
        checkOutput("reset_adr", 64'(imem_write_adr), 64'h0);
        checkOutput("reset_data", 64'(imem_in), 64'h0);
        checkOutput("reset_flags{wr,rdy,ovr,short}", 64'({imem_write, frame_ready, err_overrun, err_short}), 64'h0);
        checkOutput("reset_cks", 64'(checksum), 64'h0);
        waitCycles(2);
        reset_n = 1'b1;
        load_en = 1'b1;
        waitCycles(3);

        // Full frame, no burst
        sendBytes(64'h0155123456789A, 7);
        checkOutput("t1_ready", 64'(frame_ready), 64'h1);
        checkOutput("t1_cks", 64'(checksum), 64'hC6);
        mark = dutPulses;
        sendWrite();
        checkOutput("t1_pulses", 64'(dutPulses - mark), 64'h1);
        checkOutput("t1_adr", 64'(imem_write_adr), 64'h155);
        checkOutput("t1_data", 64'(imem_in), 64'h123456789A);
        checkOutput("t1_model_adr", 64'(expAdr), 64'h155);
        checkOutput("t1_ready_low", 64'(frame_ready), 64'h0);

        // Overrun: extra beat dropped, original frame still commits
        sendBytes(64'h0123456789ABCD, 7);
        sendBeat(8'hEE);
        checkOutput("t3_overrun", 64'(err_overrun), 64'h1);
        checkOutput("t3_cks", 64'(checksum), 64'h29);
        mark = dutPulses;
        sendWrite();
        checkOutput("t3_pulses", 64'(dutPulses - mark), 64'h1);
        checkOutput("t3_adr", 64'(imem_write_adr), 64'h123);
        checkOutput("t3_data", 64'(imem_in), 64'h456789ABCD);

        // Burst with address wrap
        auto_inc = 1'b1;
        restartSession();
        checkOutput("t2_ovr_cleared", 64'(err_overrun), 64'h0);
        sendBytes(64'h03FF0000000001, 7);
        sendWrite();
        checkOutput("t2_adr0", 64'(imem_write_adr), 64'h3FF);
        checkOutput("t2_data0", 64'(imem_in), 64'h1);
        sendBytes(64'h0000000002, 5);
        checkOutput("t2_ready_burst", 64'(frame_ready), 64'h1);
        mark = dutPulses;
        sendWrite();
        checkOutput("t2_pulses", 64'(dutPulses - mark), 64'h1);
        checkOutput("t2_adr_wrap", 64'(imem_write_adr), 64'h000);
        checkOutput("t2_data1", 64'(imem_in), 64'h2);

        // Short frame then completion
        auto_inc = 1'b0;
        waitCycles(1);
        sendBytes(64'h02AA11, 3);
        mark = dutPulses;
        sendWrite();
        checkOutput("t4_short", 64'(err_short), 64'h1);
        checkOutput("t4_no_pulse", 64'(dutPulses - mark), 64'h0);
        sendBytes(64'h22334455, 4);
        checkOutput("t4_ready", 64'(frame_ready), 64'h1);
        sendWrite();
        checkOutput("t4_pulses", 64'(dutPulses - mark), 64'h1);
        checkOutput("t4_adr", 64'(imem_write_adr), 64'h2AA);
        checkOutput("t4_data", 64'(imem_in), 64'h1122334455);

        // Abort mid-frame
        mark = dutPulses;
        sendBytes(64'h01020304, 4);
        load_en = 1'b0;
        waitCycles(2);
        checkOutput("t5_cks", 64'(checksum), 64'h0);
        checkOutput("t5_flags{rdy,ovr,short}", 64'({frame_ready, err_overrun, err_short}), 64'h0);
        checkOutput("t5_adr_held", 64'(imem_write_adr), 64'h2AA);
        checkOutput("t5_data_held", 64'(imem_in), 64'h1122334455);
        checkOutput("t5_no_pulse", 64'(dutPulses - mark), 64'h0);
        load_en = 1'b1;
        waitCycles(2);

        // Strobe and write together in READY
        sendBytes(64'h00100000000007, 7);
        mark = dutPulses;
        sendBoth(8'h5A);
        checkOutput("t6_pulses", 64'(dutPulses - mark), 64'h1);
        checkOutput("t6_adr", 64'(imem_write_adr), 64'h010);
        checkOutput("t6_data", 64'(imem_in), 64'h7);
        checkOutput("t6_cks_next", 64'(checksum), 64'h5A ^ 64'h10 ^ 64'h07);
        sendBytes(64'h0, 6);
        checkOutput("t6_ready", 64'(frame_ready), 64'h1);
        sendWrite();
        checkOutput("t6_adr_next", 64'(imem_write_adr), 64'h200);

        // Asynchronous reset while READY
        sendBytes(64'hFFFFFFFFFFFFFF, 7);
        checkOutput("t7_ready", 64'(frame_ready), 64'h1);
        @(posedge clk_int);
        #3 reset_n = 1'b0;
        #1;
        checkOutput("t7_adr", 64'(imem_write_adr), 64'h0);
        checkOutput("t7_data", 64'(imem_in), 64'h0);
        checkOutput("t7_flags{wr,rdy,ovr,short}", 64'({imem_write, frame_ready, err_overrun, err_short}), 64'h0);
        checkOutput("t7_cks", 64'(checksum), 64'h0);
        mark = dutPulses;
        waitCycles(2);
        reset_n = 1'b1;
        waitCycles(4);
        checkOutput("t7_no_pulse", 64'(dutPulses - mark), 64'h0);

        applyStimulus(150);
        waitCycles(12);
        checkOutput("total_pulses", 64'(dutPulses), 64'(expPulses));

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
